// File: rtl/fpu_adder_arbiter.sv
// Round-robin arbiter sharing one 24-bit mantissa adder between NREQ controller clients.
// One transaction in flight; operands captured at grant; watchdog answers with Exc=2'b11.
module fpu_adder_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [NREQ-1:0]      Req_valid,
  input  logic [NREQ*24-1:0]   Req_datain1,
  input  logic [NREQ*24-1:0]   Req_datain2,
  output logic [NREQ-1:0]      Req_ack,
  output logic [23:0]          Req_dataout,
  output logic                 Req_carryout,
  output logic [1:0]           Req_Exc,
  output logic                 Adder_valid,
  output logic [23:0]          Adder_datain1,
  output logic [23:0]          Adder_datain2,
  input  logic                 Adder_ack,
  input  logic [23:0]          Adder_dataout,
  input  logic                 Adder_carryout,
  input  logic [1:0]           Adder_Exc,
  output logic [1:0]           Grant_id,
  output logic                 Busy
);

  // Handshake: a client holds Req_valid and its operands until it sees its one-cycle
  // Req_ack; towards the adder, Adder_valid and operands stay stable until Adder_ack.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_e;

  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      grant_q, grant_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            av_q, av_d;
  logic [23:0]     a1_q, a1_d;
  logic [23:0]     a2_q, a2_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [23:0]     dout_q, dout_d;
  logic            cout_q, cout_d;
  logic [1:0]      exc_q, exc_d;
  logic            busy_q, busy_d;

  logic [3:0]      req_pad;
  logic [2:0]      pos;
  logic            found;
  logic [1:0]      winner;
  logic [23:0]     win_a, win_b;
  logic [NREQ-1:0] grant_onehot;

  assign req_pad = 4'(Req_valid);

  // Rotating priority: scan last_grant+1, +2, ... wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    pos    = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = 3'(last_q) + 3'(k);
      if (pos >= 3'(NREQ)) pos = pos - 3'(NREQ);
      if (!found && req_pad[pos[1:0]]) begin
        found  = 1'b1;
        winner = pos[1:0];
      end
    end
  end

  always_comb begin
    win_a = 24'd0;
    win_b = 24'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 2'(i)) begin
        win_a = Req_datain1[24*i +: 24];
        win_b = Req_datain2[24*i +: 24];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) grant_onehot[i] = (grant_q == 2'(i));
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    av_d    = av_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    ack_d   = '0;
    dout_d  = dout_q;
    cout_d  = cout_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = winner;
          a1_d    = win_a;
          a2_d    = win_b;
          av_d    = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A real answer wins over the watchdog when both land in the same cycle.
        if (Adder_ack) begin
          dout_d  = Adder_dataout;
          cout_d  = Adder_carryout;
          exc_d   = Adder_Exc;
          av_d    = 1'b0;
          ack_d   = grant_onehot;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = 24'd0;
          cout_d  = 1'b0;
          exc_d   = 2'b11;
          av_d    = 1'b0;
          ack_d   = grant_onehot;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_DRAIN;
      S_DRAIN: begin
        // Waiting out the served client's stale valid and any late adder answer.
        if (!req_pad[grant_q] && !Adder_ack) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      grant_q <= 2'd0;
      cnt_q   <= 8'd0;
      av_q    <= 1'b0;
      a1_q    <= 24'd0;
      a2_q    <= 24'd0;
      ack_q   <= '0;
      dout_q  <= 24'd0;
      cout_q  <= 1'b0;
      exc_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      av_q    <= av_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      exc_q   <= exc_d;
      busy_q  <= busy_d;
    end
  end

  assign Req_ack       = ack_q;
  assign Req_dataout   = dout_q;
  assign Req_carryout  = cout_q;
  assign Req_Exc       = exc_q;
  assign Adder_valid   = av_q;
  assign Adder_datain1 = a1_q;
  assign Adder_datain2 = a2_q;
  assign Grant_id      = grant_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// Directed bench for fpu_adder_arbiter: a transaction-level round-robin model checked
// every cycle, plus hand-computed expectations for single, contention, timeout and reset cases.
module tb_fpu_adder_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic [NREQ-1:0]   Req_valid;
  logic [NREQ*24-1:0] Req_datain1, Req_datain2;
  logic [NREQ-1:0]   Req_ack;
  logic [23:0]       Req_dataout;
  logic              Req_carryout;
  logic [1:0]        Req_Exc;
  logic              Adder_valid;
  logic [23:0]       Adder_datain1, Adder_datain2;
  logic              Adder_ack;
  logic [23:0]       Adder_dataout;
  logic              Adder_carryout;
  logic [1:0]        Adder_Exc;
  logic [1:0]        Grant_id;
  logic              Busy;

  fpu_adder_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Req_valid(Req_valid), .Req_datain1(Req_datain1), .Req_datain2(Req_datain2),
    .Req_ack(Req_ack), .Req_dataout(Req_dataout), .Req_carryout(Req_carryout), .Req_Exc(Req_Exc),
    .Adder_valid(Adder_valid), .Adder_datain1(Adder_datain1), .Adder_datain2(Adder_datain2),
    .Adder_ack(Adder_ack), .Adder_dataout(Adder_dataout), .Adder_carryout(Adder_carryout),
    .Adder_Exc(Adder_Exc), .Grant_id(Grant_id), .Busy(Busy)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [26:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      automatic int c = (last + k) % NREQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // inputs as seen by the DUT at each active edge
  logic               rst_at_edge = 1'b0;
  logic [NREQ-1:0]    req_at_edge;
  logic [NREQ*24-1:0] a_at_edge, b_at_edge;
  always @(posedge CLK) begin
    rst_at_edge = RSTn;
    req_at_edge = Req_valid;
    a_at_edge   = Req_datain1;
    b_at_edge   = Req_datain2;
  end

  // scoreboard / model
  int          mdl_last   = NREQ - 1;
  bit          inflight   = 1'b0;
  int          exp_client = 0;
  int          exp_g      = 0;
  int          av_cnt     = 0;
  logic        av_prev    = 1'b0;
  logic [23:0] exp_a, exp_b;
  logic [26:0] e;

  always @(negedge CLK) begin
    if (!rst_at_edge) begin
      inflight = 1'b0;
      mdl_last = NREQ - 1;
      exp_q.delete();
      av_prev  = 1'b0;
      av_cnt   = 0;
      check("reset_ctl", {Req_ack, Adder_valid, Busy, Grant_id, Req_Exc, Req_carryout}, 64'd0);
      check("reset_data", {Req_dataout, Adder_datain1, Adder_datain2}, 64'd0);
    end else begin
      check("ack_onehot0", 64'($countones(Req_ack) <= 1), 64'd1);
      if (Adder_valid && !av_prev) begin
        exp_g = rr_pick(req_at_edge, mdl_last);
        check("grant_found", 64'(exp_g >= 0), 64'd1);
        check("grant_id", 64'(Grant_id), 64'(exp_g[1:0]));
        if (exp_g >= 0) begin
          exp_a = a_at_edge[24*exp_g +: 24];
          exp_b = b_at_edge[24*exp_g +: 24];
        end
        inflight   = 1'b1;
        exp_client = exp_g;
        av_cnt     = 0;
      end
      if (Adder_valid) begin
        av_cnt++;
        check("op_a", 64'(Adder_datain1), 64'(exp_a));
        check("op_b", 64'(Adder_datain2), 64'(exp_b));
      end
      if (Req_ack != '0) begin
        check("ack_expected", 64'(inflight), 64'd1);
        check("ack_client", 64'(Req_ack), 64'(1) << exp_client);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("result", 64'({Req_Exc, Req_carryout, Req_dataout}), 64'(e));
        end else begin
          check("timeout_result", 64'({Req_Exc, Req_carryout, Req_dataout}), 64'({2'b11, 1'b0, 24'h0}));
          check("timeout_len", 64'(av_cnt), 64'(TIMEOUT));
        end
        if (exp_client >= 0) mdl_last = exp_client;
        inflight = 1'b0;
      end
      av_prev = Adder_valid;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b);
    Req_valid[i] = 1'b1;
    Req_datain1[24*i +: 24] = a;
    Req_datain2[24*i +: 24] = b;
  endtask

  task automatic adder_reply(input int lat, input logic [23:0] s, input logic c,
                             input logic [1:0] x, input bit fwd);
    repeat (lat) tick();
    Adder_ack      = 1'b1;
    Adder_dataout  = s;
    Adder_carryout = c;
    Adder_Exc      = x;
    if (fwd) exp_q.push_back({x, c, s});
    tick();
    Adder_ack      = 1'b0;
    Adder_dataout  = 24'($urandom);
    Adder_carryout = 1'($urandom_range(0, 1));
    Adder_Exc      = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_av(input string name);
    int n;
    n = 0;
    while (!Adder_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(Adder_valid), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(Busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  int n;

  initial begin
    RSTn           = 1'b0;
    Req_valid      = '0;
    Req_datain1    = '0;
    Req_datain2    = '0;
    Adder_ack      = 1'b0;
    Adder_dataout  = 24'h0;
    Adder_carryout = 1'b0;
    Adder_Exc      = 2'b00;
    tick();
    tick();
    check("rst_state", 64'({Req_ack, Adder_valid, Busy, Grant_id, Req_Exc, Req_carryout, Req_dataout}), 64'd0);
    RSTn = 1'b1;
    tick();

    // T1 single transaction; operand change after grant must be ignored
    set_req(0, 24'h800000, 24'h800000);
    tick();
    check("t1_av_latency", 64'(Adder_valid), 64'd1);
    check("t1_grant", 64'(Grant_id), 64'd0);
    check("t1_op_a", 64'(Adder_datain1), 64'h800000);
    Req_datain1[23:0] = 24'h123456;
    adder_reply(3, 24'h000000, 1'b1, 2'b00, 1'b1);
    check("t1_ack", 64'(Req_ack), 64'b01);
    check("t1_sum", 64'(Req_dataout), 64'h0);
    check("t1_carry", 64'(Req_carryout), 64'd1);
    check("t1_av_drop", 64'(Adder_valid), 64'd0);
    tick();
    check("t1_ack_pulse", 64'(Req_ack), 64'd0);
    Req_valid[0] = 1'b0;
    wait_idle("t1_idle");

    // T4 exception pass-through on client 1
    set_req(1, 24'h000001, 24'h000000);
    tick();
    check("t4_grant", 64'(Grant_id), 64'd1);
    adder_reply(2, 24'h000001, 1'b0, 2'b01, 1'b1);
    check("t4_ack", 64'(Req_ack), 64'b10);
    check("t4_exc", 64'(Req_Exc), 64'b01);
    check("t4_sum", 64'(Req_dataout), 64'h000001);
    Req_valid[1] = 1'b0;
    wait_idle("t4_idle");

    // T2 contention: 0 then 1, then 0 again
    set_req(0, 24'h111111, 24'h222222);
    set_req(1, 24'h333333, 24'h444444);
    tick();
    check("t2_first_grant", 64'(Grant_id), 64'd0);
    adder_reply(2, 24'h333333, 1'b0, 2'b00, 1'b1);
    check("t2_ack0", 64'(Req_ack), 64'b01);
    Req_valid[0] = 1'b0;
    wait_av("t2_second_av");
    check("t2_second_grant", 64'(Grant_id), 64'd1);
    check("t2_second_op_a", 64'(Adder_datain1), 64'h333333);
    adder_reply(1, 24'h777777, 1'b0, 2'b00, 1'b1);
    check("t2_ack1", 64'(Req_ack), 64'b10);
    Req_valid[1] = 1'b0;
    wait_idle("t2_idle");
    set_req(0, 24'h0000aa, 24'h0000bb);
    set_req(1, 24'h0000cc, 24'h0000dd);
    tick();
    check("t2_third_grant", 64'(Grant_id), 64'd0);
    adder_reply(1, 24'h000165, 1'b0, 2'b00, 1'b1);
    check("t2_ack2", 64'(Req_ack), 64'b01);
    Req_valid[0] = 1'b0;
    wait_av("t2_fourth_av");
    check("t2_fourth_grant", 64'(Grant_id), 64'd1);
    adder_reply(2, 24'h0001a9, 1'b0, 2'b00, 1'b1);
    check("t2_ack3", 64'(Req_ack), 64'b10);
    Req_valid[1] = 1'b0;
    wait_idle("t2_idle2");

    // T3 watchdog timeout, then a late adder answer that must be swallowed
    set_req(0, 24'h0f0f0f, 24'h00f00f);
    tick();
    n = 0;
    while (Adder_valid && n < 100) begin
      tick();
      n++;
    end
    check("t3_av_cycles", 64'(n), 64'd16);
    check("t3_ack", 64'(Req_ack), 64'b01);
    check("t3_exc", 64'(Req_Exc), 64'b11);
    check("t3_sum", 64'(Req_dataout), 64'h0);
    tick();
    adder_reply(0, 24'habcdef, 1'b1, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t3_no_late_ack", 64'({Req_ack, Busy}), 64'b001);
      check("t3_result_hold", 64'({Req_Exc, Req_dataout}), 64'({2'b11, 24'h0}));
      tick();
    end
    Req_valid[0] = 1'b0;
    wait_idle("t3_idle");

    // T5 sticky valid keeps the arbiter in DRAIN
    set_req(0, 24'h5a5a5a, 24'h000000);
    tick();
    check("t5_grant", 64'(Grant_id), 64'd0);
    adder_reply(2, 24'h5a5a5a, 1'b0, 2'b00, 1'b1);
    check("t5_ack", 64'(Req_ack), 64'b01);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold", 64'({Busy, Adder_valid, Req_ack}), 64'b1000);
    end
    Req_valid[0] = 1'b0;
    wait_idle("t5_idle");

    // T6 reset mid-WAIT restores client-0 priority
    set_req(1, 24'h00beef, 24'h000001);
    tick();
    check("t6_wait", 64'({Adder_valid, Grant_id}), 64'b101);
    RSTn = 1'b0;
    tick();
    check("t6_reset_out", 64'({Req_ack, Adder_valid, Busy, Grant_id, Req_Exc, Req_carryout, Req_dataout}), 64'd0);
    check("t6_reset_ops", 64'({Adder_datain1, Adder_datain2}), 64'd0);
    RSTn = 1'b1;
    set_req(0, 24'h00cafe, 24'h000002);
    tick();
    check("t6_priority", 64'({Adder_valid, Grant_id}), 64'b100);
    adder_reply(1, 24'h00cb00, 1'b0, 2'b00, 1'b1);
    check("t6_ack0", 64'(Req_ack), 64'b01);
    Req_valid[0] = 1'b0;
    wait_av("t6_second_av");
    check("t6_second_grant", 64'(Grant_id), 64'd1);
    adder_reply(2, 24'h00bef0, 1'b0, 2'b00, 1'b1);
    check("t6_ack1", 64'(Req_ack), 64'b10);
    Req_valid[1] = 1'b0;
    wait_idle("t6_idle");

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
